// File: rtl/rom_stream_reader.sv
// Sweeps a contiguous ROM address window and streams each word out on a valid/ready
// port, keeping an XOR checksum of the words that were accepted.
//
// state | meaning
// IDLE  | waiting for start; start with length 0 goes straight to DONE
// RUN   | issuing reads and draining the output FIFO
// DONE  | one-cycle done pulse, then back to IDLE
module rom_stream_reader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready
);

   localparam int CW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           len_q;
   logic [CW-1:0]           issued;
   logic [CW-1:0]           beat_cnt;
   logic [RD_LATENCY-1:0]   inflight;
   logic [DATA_WIDTH-1:0]   fifo_mem [4];
   logic [1:0]              wr_ptr;
   logic [1:0]              rd_ptr;
   logic [2:0]              fifo_cnt;
   logic [2:0]              outstanding;
   logic                    issue;
   logic                    push;
   logic                    pop;

   // Credits cover reads in flight plus words already queued, so the FIFO cannot overflow.
   always_comb begin
      outstanding = fifo_cnt;
      for (int i = 0; i < RD_LATENCY; i++) begin
         outstanding = outstanding + 3'(inflight[i]);
      end
   end

   assign issue   = (state == RUN) && (issued < len_q) && (outstanding < 3'd4);
   assign push    = inflight[RD_LATENCY-1];
   assign m_valid = (fifo_cnt != 3'd0);
   assign pop     = m_valid && m_ready;
   assign m_last  = m_valid && (beat_cnt == len_q - CW'(1));
   assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= rom_rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         len_q    <= '0;
         issued   <= '0;
         beat_cnt <= '0;
         checksum <= '0;
         rom_addr <= '0;
         inflight <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         inflight[0] <= issue;
         for (int i = 1; i < RD_LATENCY; i++) begin
            inflight[i] <= inflight[i-1];
         end

         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);

         // rom_addr always holds base + issued, so the ROM samples the issue address.
         if (issue) begin
            issued   <= issued + CW'(1);
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
         end

         if (pop) begin
            beat_cnt <= beat_cnt + CW'(1);
            checksum <= checksum ^ m_data;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= length;
                  issued   <= '0;
                  beat_cnt <= '0;
                  checksum <= '0;
                  rom_addr <= base_addr;
                  if (length == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (pop && m_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: table of transfers checked against a queue-based
// model of the expected stream, plus a mid-transfer reset sequence.
module tb_rom_stream_reader;

   localparam int AW = 10;
   localparam int DW = 64;
   localparam int RL = 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic [DW-1:0] checksum;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_rd_data;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_ready;

   int checks = 0;
   int errors = 0;

   rom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .checksum(checksum), .rom_addr(rom_addr),
      .rom_rd_data(rom_rd_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
      .m_ready(m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-output ROM: address sampled, then one output register stage.
   logic [DW-1:0] rom_mem [1024];
   logic [DW-1:0] rom_p1;
   logic [DW-1:0] rom_p2;
   always @(posedge clk) begin
      rom_p1 <= rom_mem[rom_addr];
      rom_p2 <= rom_p1;
   end
   assign rom_rd_data = rom_p2;

   typedef struct {
      logic [AW-1:0] base;
      int            len;
      int            ready_pct;
      int            stall;
      bit            rom_ident;
      int            restart_cyc;
      bit            start_at_done;
      int            exp_done;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_xfer(input vec_t v);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] exp_sum = '0;
      logic [DW-1:0] prev_data = '0;
      logic [AW-1:0] prev_addr;
      int beat = 0, cyc = 0, done_cyc = -1, done_cnt = 0, first_valid = -1;
      int stall_left = v.stall, issues = 0, hs = 0, max_out = 0, bad_step = 0;
      int last_acc_cyc = -10, post = 0;
      int limit = 30 * v.len + 100;
      bit done_seen = 0, prev_stall = 0, last_acc = 0, ready, exp_busy, exp_dn;

      for (int i = 0; i < v.len; i++) begin
         int a;
         a = (int'(v.base) + i) % 1024;
         exp_q.push_back(rom_mem[a]);
         exp_sum ^= rom_mem[a];
      end

      @(negedge clk);
      start     = 1'b1;
      base_addr = v.base;
      length    = 11'(v.len);
      m_ready   = 1'b0;
      prev_addr = v.base;

      while (cyc < limit) begin
         @(negedge clk);
         cyc++;
         start = (cyc == v.restart_cyc);

         if (cyc == 1 && v.len != 0) chk("rom_addr_first", rom_addr, v.base);
         if (rom_addr != prev_addr) begin
            issues++;
            if (rom_addr != AW'(prev_addr + 1'b1)) bad_step++;
            prev_addr = rom_addr;
         end
         if (!done_seen && issues - hs > max_out) max_out = issues - hs;

         exp_busy = (v.len != 0) && !last_acc;
         exp_dn   = (v.len == 0) ? (cyc == 1) : (last_acc_cyc == cyc - 1);
         chk("busy", busy, exp_busy);
         chk("done", done, exp_dn);

         if (stall_left > 0 && (first_valid >= 0 || m_valid)) begin
            ready = 1'b0;
            stall_left--;
         end else begin
            ready = ($urandom_range(99) < v.ready_pct);
         end

         if (m_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (prev_stall) chk("data_stable", m_data, prev_data);
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk("m_last", m_last, (beat == v.len - 1));
            if (ready) begin
               if (exp_q.size() != 0) chk("m_data", m_data, exp_q.pop_front());
               hs++;
               beat++;
               if (beat == v.len) begin
                  last_acc = 1;
                  last_acc_cyc = cyc;
               end
            end
            prev_stall = !ready;
            prev_data  = m_data;
         end else begin
            prev_stall = 0;
            chk("m_last_idle", m_last, 0);
         end
         m_ready = ready;

         if (done) begin
            done_cnt++;
            if (!done_seen) begin
               done_seen = 1;
               done_cyc  = cyc;
               chk("checksum_done", checksum, exp_sum);
               if (v.start_at_done) start = 1'b1;
            end
         end
         if (done_seen) begin
            post++;
            if (post > 4) break;
         end
      end

      if (!done_seen) chk("timeout_done", 0, 1);
      start   = 1'b0;
      m_ready = 1'b0;
      chk("beat_count", beat, v.len);
      chk("done_count", done_cnt, 1);
      chk("issue_count", issues, v.len);
      chk("addr_step_errors", bad_step, 0);
      chk("max_outstanding_le4", (max_out <= 4), 1);
      chk("checksum_hold", checksum, exp_sum);
      if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
      if (v.exp_done >= 0 && v.len > 0) chk("first_valid_cycle", first_valid, 2 + RL);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_checksum"}, checksum, 0);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_m_last"}, m_last, 0);
   endtask

   task automatic fill_rom(input bit ident);
      for (int i = 0; i < 1024; i++) rom_mem[i] = ident ? 64'(i) : {$urandom, $urandom};
   endtask

   vec_t vt[12];

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      m_ready   = 1'b0;
      fill_rom(1);
      #1;
      chk_outputs_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      vt[0] = '{10'h000, 4,    100, 0,  1, 0, 0, 8};
      vt[1] = '{10'h3FE, 4,    100, 0,  0, 0, 0, 8};
      vt[2] = '{10'h000, 16,   100, 10, 0, 0, 0, 30};
      vt[3] = '{10'h012, 0,    100, 0,  0, 0, 0, 1};
      vt[4] = '{10'h000, 8,    100, 0,  0, 3, 1, 12};
      vt[5] = '{10'h155, 1024, 50,  0,  0, 0, 0, -1};
      for (int i = 6; i < 12; i++) begin
         vt[i].base          = 10'($urandom_range(0, 1023));
         vt[i].len           = $urandom_range(1, 40);
         vt[i].ready_pct     = (i == 6) ? 100 : $urandom_range(30, 100);
         vt[i].stall         = (i == 7) ? 6 : 0;
         vt[i].rom_ident     = 0;
         vt[i].restart_cyc   = 0;
         vt[i].start_at_done = i[0];
         vt[i].exp_done      = (vt[i].ready_pct == 100 && vt[i].stall == 0) ?
                               2 + RL + vt[i].len : -1;
      end

      for (int i = 0; i < 12; i++) begin
         fill_rom(vt[i].rom_ident);
         run_xfer(vt[i]);
      end

      // Reset in cycle 6 of a length-8 transfer, then a fresh length-2 transfer.
      fill_rom(0);
      @(negedge clk);
      start     = 1'b1;
      base_addr = 10'h020;
      length    = 11'd8;
      m_ready   = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("midreset");
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      m_ready = 1'b0;
      @(negedge clk);
      run_xfer('{10'h040, 2, 100, 0, 0, 0, 0, 2 + RL + 2});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
